// File: rtl/video_text_writer.sv
// Byte-stream to video-memory cell writer: cursor tracking, ESC 'Y' row/col moves and full-screen clear.
// Optional auto-wrap at end of line is enabled by defining VIDEO_TEXT_WRITER_WRAP_EN.
`ifndef TEXTCOLS_CHAR
`define TEXTCOLS_CHAR 40
`endif
`ifndef TEXTROWS_CHAR
`define TEXTROWS_CHAR 25
`endif
`ifndef TEXTCOLS_RANGE
`define TEXTCOLS_RANGE 5:0
`endif
`ifndef TEXTROWS_RANGE
`define TEXTROWS_RANGE 4:0
`endif
`ifndef CHARATTR_RANGE
`define CHARATTR_RANGE 15:0
`endif
`ifndef CHARATTR_INDEX
`define CHARATTR_INDEX 7:0
`endif

module video_text_writer #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter logic [7:0] ESC_BASE   = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic [`CHARATTR_RANGE] attr,
  output logic                   busy,
  output logic                   write,
  output logic [`TEXTCOLS_RANGE] xtextwrite,
  output logic [`TEXTROWS_RANGE] ytextwrite,
  output logic [`CHARATTR_RANGE] value,
  output logic [`TEXTCOLS_RANGE] cur_x,
  output logic [`TEXTROWS_RANGE] cur_y
);
  typedef logic [`TEXTCOLS_RANGE] col_t;
  typedef logic [`TEXTROWS_RANGE] row_t;
  typedef logic [`CHARATTR_RANGE] cell_t;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ESC     = 3'd1;
  localparam logic [2:0] ESC_ROW = 3'd2;
  localparam logic [2:0] ESC_COL = 3'd3;
  localparam logic [2:0] CLEAR   = 3'd4;

  localparam col_t       COL_LAST = col_t'(`TEXTCOLS_CHAR - 1);
  localparam row_t       ROW_LAST = row_t'(`TEXTROWS_CHAR - 1);
  localparam logic [7:0] COL_MAX8 = 8'(`TEXTCOLS_CHAR - 1);
  localparam logic [7:0] ROW_MAX8 = 8'(`TEXTROWS_CHAR - 1);

  logic [2:0] state_reg, state_next;
  logic       ready_reg, ready_next;
  logic       busy_reg, busy_next;
  logic       write_reg, write_next;
  col_t       xw_reg, xw_next, cx_reg, cx_next;
  row_t       yw_reg, yw_next, cy_reg, cy_next, esc_row_reg, esc_row_next;
  cell_t      value_reg, value_next;
  logic       accept;
  logic [7:0] esc_off;

  function automatic cell_t make_cell(input cell_t a, input logic [7:0] idx);
    cell_t c;
    c = a;
    c[`CHARATTR_INDEX] = idx;
    return c;
  endfunction

  function automatic row_t row_inc(input row_t r);
    return (r == ROW_LAST) ? '0 : r + row_t'(1);
  endfunction

  assign accept  = in_valid && ready_reg;
  assign esc_off = in_data - ESC_BASE;

  always_comb begin
    state_next   = state_reg;
    write_next   = 1'b0;
    xw_next      = xw_reg;
    yw_next      = yw_reg;
    value_next   = value_reg;
    cx_next      = cx_reg;
    cy_next      = cy_reg;
    esc_row_next = esc_row_reg;
    case (state_reg)
      IDLE: if (accept) begin
        if (in_data >= 8'h20) begin
          write_next = 1'b1;
          xw_next    = cx_reg;
          yw_next    = cy_reg;
          value_next = make_cell(attr, in_data);
          if (cx_reg != COL_LAST) begin
            cx_next = cx_reg + col_t'(1);
          end else begin
`ifdef VIDEO_TEXT_WRITER_WRAP_EN
            cx_next = '0;
            cy_next = row_inc(cy_reg);
`endif
          end
        end else begin
          case (in_data)
            8'h08: if (cx_reg != '0) cx_next = cx_reg - col_t'(1);
            8'h0D: cx_next = '0;
            8'h0A: cy_next = row_inc(cy_reg);
            8'h0C: begin
              // First clear cell goes out on the accepting edge; attr is captured once here.
              state_next = CLEAR;
              write_next = 1'b1;
              xw_next    = '0;
              yw_next    = '0;
              value_next = make_cell(attr, CLEAR_CHAR);
            end
            8'h1B: state_next = ESC;
            default: ;
          endcase
        end
      end
      ESC: if (accept) state_next = (in_data == 8'h59) ? ESC_ROW : IDLE;
      ESC_ROW: if (accept) begin
        if (in_data < ESC_BASE)       esc_row_next = '0;
        else if (esc_off > ROW_MAX8)  esc_row_next = ROW_LAST;
        else                          esc_row_next = row_t'(esc_off);
        state_next = ESC_COL;
      end
      ESC_COL: if (accept) begin
        if (in_data < ESC_BASE)       cx_next = '0;
        else if (esc_off > COL_MAX8)  cx_next = COL_LAST;
        else                          cx_next = col_t'(esc_off);
        cy_next    = esc_row_reg;
        state_next = IDLE;
      end
      CLEAR: begin
        if (xw_reg == COL_LAST && yw_reg == ROW_LAST) begin
          state_next = IDLE;
          cx_next    = '0;
          cy_next    = '0;
        end else begin
          write_next = 1'b1;
          if (xw_reg == COL_LAST) begin
            xw_next = '0;
            yw_next = yw_reg + row_t'(1);
          end else begin
            xw_next = xw_reg + col_t'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next  = (state_next == CLEAR);
    ready_next = (state_next != CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      write_reg   <= 1'b0;
      xw_reg      <= '0;
      yw_reg      <= '0;
      value_reg   <= '0;
      cx_reg      <= '0;
      cy_reg      <= '0;
      esc_row_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
      write_reg   <= write_next;
      xw_reg      <= xw_next;
      yw_reg      <= yw_next;
      value_reg   <= value_next;
      cx_reg      <= cx_next;
      cy_reg      <= cy_next;
      esc_row_reg <= esc_row_next;
    end
  end

  assign in_ready   = ready_reg;
  assign busy       = busy_reg;
  assign write      = write_reg;
  assign xtextwrite = xw_reg;
  assign ytextwrite = yw_reg;
  assign value      = value_reg;
  assign cur_x      = cx_reg;
  assign cur_y      = cy_reg;
endmodule

// File: tb/tb_video_text_writer.sv
// Directed, table-driven bench for video_text_writer on a 40x25 grid with 16-bit cells (index in [7:0]).
`ifndef TEXTCOLS_CHAR
`define TEXTCOLS_CHAR 40
`endif
`ifndef TEXTROWS_CHAR
`define TEXTROWS_CHAR 25
`endif
`ifndef TEXTCOLS_RANGE
`define TEXTCOLS_RANGE 5:0
`endif
`ifndef TEXTROWS_RANGE
`define TEXTROWS_RANGE 4:0
`endif
`ifndef CHARATTR_RANGE
`define CHARATTR_RANGE 15:0
`endif
`ifndef CHARATTR_INDEX
`define CHARATTR_INDEX 7:0
`endif

module tb_video_text_writer;
  localparam int NCOLS  = 40;
  localparam int NROWS  = 25;
  localparam int NCELLS = NCOLS * NROWS;
`ifdef VIDEO_TEXT_WRITER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [15:0] attr = 16'h0000;
  logic        busy, write;
  logic [5:0]  xtextwrite, cur_x;
  logic [4:0]  ytextwrite, cur_y;
  logic [15:0] value;

  video_text_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .attr(attr), .busy(busy), .write(write), .xtextwrite(xtextwrite), .ytextwrite(ytextwrite),
    .value(value), .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [15:0] a;
    logic        w;
    logic [5:0]  ex;
    logic [4:0]  ey;
    logic [15:0] ev;
    logic [5:0]  cx;
    logic [4:0]  cy;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic add(input logic [7:0] b, input logic [15:0] a, input logic w, input logic [5:0] ex,
                     input logic [4:0] ey, input logic [15:0] ev, input logic [5:0] cx, input logic [4:0] cy);
    vec_t v;
    v.b = b; v.a = a; v.w = w; v.ex = ex; v.ey = ey; v.ev = ev; v.cx = cx; v.cy = cy;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input logic [15:0] a);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    attr     = a;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int cycles, bad;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_write", {31'b0, write}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_xy_val", {10'b0, xtextwrite, ytextwrite, value}, 0);
    check("rst_cursor", {21'b0, cur_x, cur_y}, 0);
    reset = 1'b1;
    @(negedge clk);

    //   byte    attr      w  ex  ey  value     cx  cy
    add(8'h41, 16'hA500, 1, 0,  0,  16'hA541, 1,  0);
    add(8'h1B, 16'h0000, 0, 0,  0,  16'h0,    1,  0);
    add(8'h59, 16'h0000, 0, 0,  0,  16'h0,    1,  0);
    add(8'h25, 16'h0000, 0, 0,  0,  16'h0,    1,  0);
    add(8'h2A, 16'h0000, 0, 0,  0,  16'h0,    10, 5);
    add(8'h42, 16'h3C00, 1, 10, 5,  16'h3C42, 11, 5);
    add(8'h1B, 16'h0000, 0, 0,  0,  16'h0,    11, 5);
    add(8'h59, 16'h0000, 0, 0,  0,  16'h0,    11, 5);
    add(8'h23, 16'h0000, 0, 0,  0,  16'h0,    11, 5);
    add(8'h27, 16'h0000, 0, 0,  0,  16'h0,    7,  3);
    add(8'h0D, 16'h0000, 0, 0,  0,  16'h0,    0,  3);
    add(8'h0A, 16'h0000, 0, 0,  0,  16'h0,    0,  4);
    add(8'h08, 16'h0000, 0, 0,  0,  16'h0,    0,  4);
    add(8'h01, 16'h0000, 0, 0,  0,  16'h0,    0,  4);
    add(8'h7F, 16'hFF00, 1, 0,  4,  16'hFF7F, 1,  4);
    add(8'h08, 16'h0000, 0, 0,  0,  16'h0,    0,  4);
    add(8'h1B, 16'h0000, 0, 0,  0,  16'h0,    0,  4);
    add(8'h59, 16'h0000, 0, 0,  0,  16'h0,    0,  4);
    add(8'h10, 16'h0000, 0, 0,  0,  16'h0,    0,  4);
    add(8'hFF, 16'h0000, 0, 0,  0,  16'h0,    39, 0);
    add(8'h43, 16'h12EE, 1, 39, 0,  16'h1243, WRAP ? 6'd0 : 6'd39, WRAP ? 5'd1 : 5'd0);
    add(8'h1B, 16'h0000, 0, 0,  0,  16'h0,    WRAP ? 6'd0 : 6'd39, WRAP ? 5'd1 : 5'd0);
    add(8'h59, 16'h0000, 0, 0,  0,  16'h0,    WRAP ? 6'd0 : 6'd39, WRAP ? 5'd1 : 5'd0);
    add(8'hFF, 16'h0000, 0, 0,  0,  16'h0,    WRAP ? 6'd0 : 6'd39, WRAP ? 5'd1 : 5'd0);
    add(8'hFF, 16'h0000, 0, 0,  0,  16'h0,    39, 24);
    add(8'h43, 16'h12EE, 1, 39, 24, 16'h1243, WRAP ? 6'd0 : 6'd39, WRAP ? 5'd0 : 5'd24);
    add(8'h0A, 16'h0000, 0, 0,  0,  16'h0,    WRAP ? 6'd0 : 6'd39, WRAP ? 5'd1 : 5'd0);
    add(8'h1B, 16'h0000, 0, 0,  0,  16'h0,    WRAP ? 6'd0 : 6'd39, WRAP ? 5'd1 : 5'd0);
    add(8'h51, 16'h0000, 0, 0,  0,  16'h0,    WRAP ? 6'd0 : 6'd39, WRAP ? 5'd1 : 5'd0);
    add(8'h45, 16'h4400, 1, WRAP ? 6'd0 : 6'd39, WRAP ? 5'd1 : 5'd0, 16'h4445,
        WRAP ? 6'd1 : 6'd39, WRAP ? 5'd1 : 5'd0);

    foreach (vecs[i]) begin
      send(vecs[i].b, vecs[i].a);
      $display("vec %0d: byte=0x%02h write=%0b x=%0d y=%0d value=0x%04h cursor=(%0d,%0d)",
               i, vecs[i].b, write, xtextwrite, ytextwrite, value, cur_x, cur_y);
      check($sformatf("vec%0d_write", i), {31'b0, write}, {31'b0, vecs[i].w});
      if (vecs[i].w) begin
        check($sformatf("vec%0d_xy", i), {21'b0, xtextwrite, ytextwrite}, {21'b0, vecs[i].ex, vecs[i].ey});
        check($sformatf("vec%0d_value", i), {16'b0, value}, {16'b0, vecs[i].ev});
      end
      check($sformatf("vec%0d_cursor", i), {21'b0, cur_x, cur_y}, {21'b0, vecs[i].cx, vecs[i].cy});
    end
    @(negedge clk);
    check("write_pulse_width", {31'b0, write}, 0);

    // full clear with in_valid held high throughout
    in_valid = 1'b1;
    in_data  = 8'h0C;
    attr     = 16'h5A00;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h5A;
    attr    = 16'h7700;
    cycles  = 0;
    bad     = 0;
    while (busy && cycles < NCELLS + 5) begin
      if (write !== 1'b1 || in_ready !== 1'b0 || value !== 16'h5A20 ||
          xtextwrite !== 6'(cycles % NCOLS) || ytextwrite !== 5'(cycles / NCOLS)) bad++;
      cycles++;
      @(negedge clk);
    end
    $display("clear: busy cycles=%0d bad cells=%0d", cycles, bad);
    check("clear_busy_cycles", cycles, NCELLS);
    check("clear_bad_cells", bad, 0);
    check("clear_done_flags", {29'b0, busy, write, in_ready}, 32'd1);
    check("clear_cursor", {21'b0, cur_x, cur_y}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    $display("after clear: write=%0b x=%0d y=%0d value=0x%04h cursor=(%0d,%0d)",
             write, xtextwrite, ytextwrite, value, cur_x, cur_y);
    check("held_byte_write", {31'b0, write}, 1);
    check("held_byte_cell", {5'b0, xtextwrite, ytextwrite, value}, {5'b0, 6'd0, 5'd0, 16'h775A});
    check("held_byte_cursor", {21'b0, cur_x, cur_y}, {21'b0, 6'd1, 5'd0});

    // reset in the middle of a clear
    send(8'h1B, 16'h0); send(8'h59, 16'h0); send(8'h22, 16'h0); send(8'h23, 16'h0);
    check("pre_clear_cursor", {21'b0, cur_x, cur_y}, {21'b0, 6'd3, 5'd2});
    send(8'h0C, 16'h6600);
    repeat (100) @(negedge clk);
    check("cell100_addr", {20'b0, busy, xtextwrite, ytextwrite}, {20'b0, 1'b1, 6'd20, 5'd2});
    #2 reset = 1'b0;
    #1;
    $display("mid-clear reset: write=%0b busy=%0b in_ready=%0b", write, busy, in_ready);
    check("abort_flags", {29'b0, write, busy, in_ready}, 0);
    check("abort_outputs", {5'b0, xtextwrite, ytextwrite, value}, 0);
    check("abort_cursor", {21'b0, cur_x, cur_y}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'h44, 16'h1100);
    $display("after abort: write=%0b x=%0d y=%0d value=0x%04h cursor=(%0d,%0d)",
             write, xtextwrite, ytextwrite, value, cur_x, cur_y);
    check("post_abort_write", {31'b0, write}, 1);
    check("post_abort_cell", {5'b0, xtextwrite, ytextwrite, value}, {5'b0, 6'd0, 5'd0, 16'h1144});
    check("post_abort_cursor", {21'b0, cur_x, cur_y}, {21'b0, 6'd1, 5'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/video_text_writer.md
Name: video_text_writer

Overview:
- Converts a byte stream (characters plus a small set of control codes) into single-cell writes to the video memory's external write port (write, xtextwrite, ytextwrite, value).
- Keeps a text cursor, supports cursor moves, and supports full-screen clear.
- Sits between a host/UART byte source and the video memory, on the same clk as the display pipeline.

Parameters:
- CLEAR_CHAR, 8'h20, character index used when filling cells during clear screen.
- ESC_BASE, 8'h20, offset subtracted from row/column bytes in the ESC 'Y' sequence.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  byte available on in_data
- in_data  input  8  command/character byte
- in_ready  output  1  block can accept a byte this cycle
- attr  input  `CHARATTR_RANGE  current attribute template; its `CHARATTR_INDEX field is ignored
- busy  output  1  clear screen in progress
- write  output  1  one-cycle write strobe to video memory
- xtextwrite  output  `TEXTCOLS_RANGE  target column
- ytextwrite  output  `TEXTROWS_RANGE  target row
- value  output  `CHARATTR_RANGE  cell contents to write
- cur_x  output  `TEXTCOLS_RANGE  cursor column
- cur_y  output  `TEXTROWS_RANGE  cursor row

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; write=0, busy=0, in_ready=0 while reset is held.
  - xtextwrite=0, ytextwrite=0, value=0, cur_x=0, cur_y=0.
  - An in-progress clear is aborted immediately.
- Handshake:
  - A byte is accepted on a rising edge with in_valid && in_ready.
  - in_ready=1 in IDLE, ESC, ESC_ROW and ESC_COL; in_ready=0 in CLEAR.
  - One byte per cycle sustained outside CLEAR.
- All outputs are registered. The write strobe rises on the edge after acceptance (latency 1) and stays high for exactly one cycle. xtextwrite, ytextwrite and value hold until the next write.
- Cell value:
  - value = attr, with the `CHARATTR_INDEX field replaced by the byte (zero-extended if the field is wider than 8 bits).
  - attr is sampled on the accepting edge.
- IDLE decode:
  - Printable byte (>=0x20, including 0x7F–0xFF): write at (cur_x, cur_y), then advance the cursor.
    - At cur_x = `TEXTCOLS_CHAR-1 the cursor wraps to x=0 and y+1.
    - At the last row, y wraps to 0. No scrolling.
  - 0x08 BS: cur_x-1 if cur_x>0, otherwise no change; no write.
  - 0x0D CR: cur_x=0; no write.
  - 0x0A LF: cur_y+1, wrapping `TEXTROWS_CHAR-1 -> 0; no write.
  - 0x0C FF: go to CLEAR.
  - 0x1B ESC: go to ESC.
  - Any other byte <0x20: ignored, no state change.
- ESC sequence:
  - In ESC, byte 'Y' (0x59) goes to ESC_ROW; any other byte returns to IDLE with no effect.
  - ESC_ROW: row = byte-ESC_BASE, clamped to `TEXTROWS_CHAR-1. If byte<ESC_BASE, row=0. Go to ESC_COL.
  - ESC_COL: column = byte-ESC_BASE, clamped to `TEXTCOLS_CHAR-1, with the same low rule. Update cur_x and cur_y together on this edge, then go to IDLE.
- CLEAR:
  - busy=1 and in_ready=0.
  - Emits `TEXTCOLS_CHAR*`TEXTROWS_CHAR consecutive write cycles, one cell per cycle, x fastest, starting at (0,0).
  - Each cell value = attr (sampled at FF acceptance, held) with index CLEAR_CHAR.
  - After the last cell (`TEXTCOLS_CHAR-1, `TEXTROWS_CHAR-1): cursor=(0,0), busy=0, state=IDLE on the following edge.
- Width rules: all cursor arithmetic is modulo the text grid; no out-of-range coordinate is ever driven on xtextwrite/ytextwrite.
- in_valid during CLEAR: the byte is not consumed and must be held by the source.

Optional Feature:
- Macro: VIDEO_TEXT_WRITER_WRAP_EN.
  - Defined: auto-wrap as described (end of line -> next row, last row -> row 0).
  - Undefined: printable writes at cur_x=`TEXTCOLS_CHAR-1 overwrite that cell and leave the cursor there. LF still wraps rows.

Test Plan:
- Reset released, 'A'(0x41) at (0,0) with attr fields set -> single write pulse next cycle, x=0, y=0, index=0x41, other fields equal attr; cursor=(1,0).
- ESC 'Y' 0x25 0x2A then 'B' -> cursor=(10,5), write at x=10, y=5, index=0x42; cursor=(11,5).
- Cursor at (`TEXTCOLS_CHAR-1, `TEXTROWS_CHAR-1), send 'C' -> write there, cursor=(0,0) with WRAP_EN; cursor unchanged without it.
- Cursor at (7,3): send 0x0D, 0x0A, 0x08 -> cursor (0,3), (0,4), (0,4); no write pulses.
- Send 0x0C -> busy=1 for exactly `TEXTCOLS_CHAR*`TEXTROWS_CHAR cycles, each cycle one write of index 0x20, addresses sequential; in_valid held high is not accepted until busy=0; cursor=(0,0).
- Assert reset=0 mid-clear at cell 100 -> write=0, busy=0 and outputs zero immediately; after release, 'D' is written at (0,0).
